mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter and access sequencer for the flintRV core. Shares one unified instruction/data memory port between the fetch stage (read-only requester "i") and the load/store stage (read/write requester "d"). Data accesses have fixed priority over fetch, with an optional starvation guard. At most one memory transaction is outstanding at a time.

## Interface
- `ADDR_W`, default 32: address width, byte address.
- `DATA_W`, default 32: data width. `DATA_W/8` byte enables.
- `STARVE_MAX`, default 4: maximum consecutive d grants while `i_req` is pending. Range 1..15. Used only with the guard compiled in.

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `i_req`  in  1  fetch request; held with `i_addr` until `i_gnt`
- `i_addr`  in  ADDR_W  fetch address
- `i_gnt`  out  1  fetch request accepted (1-cycle pulse)
- `i_rvalid`  out  1  fetch data valid (1-cycle pulse)
- `i_rdata`  out  DATA_W  fetch data
- `d_req`  in  1  load/store request; held with `d_*` until `d_gnt`
- `d_we`  in  1  1 = store, 0 = load
- `d_be`  in  DATA_W/8  byte enables (store)
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  data request accepted (1-cycle pulse)
- `d_rvalid`  out  1  load data valid, or store complete (1-cycle pulse)
- `d_rdata`  out  DATA_W  load data; 0 for store completion
- `m_req`  out  1  memory request; held stable until `m_ready`
- `m_we`, `m_be`, `m_addr`, `m_wdata`  out  1/DATA_W/8/ADDR_W/DATA_W  registered request fields
- `m_ready`  in  1  memory accepts request this cycle
- `m_rvalid`  in  1  read data return (1 or more cycles after acceptance)
- `m_rdata`  in  DATA_W  read data

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE: select a winner among the pending requesters.
  - `d_req` wins over `i_req` unless the starvation guard forces i.
  - Pulse the winner's `*_gnt` combinationally.
  - Latch the winner's fields into the `m_*` registers and the owner flag.
  - Next state: ISSUE.
  - With no request pending, stay in IDLE.
- ISSUE: `m_req`=1 with stable fields.
  - On `m_req && m_ready` for a read (fetch, or load): go to WAIT_RD.
  - On acceptance of a store: pulse `d_rvalid` that cycle with `d_rdata`=0, then go to IDLE.
  - Without `m_ready`: stay in ISSUE, fields unchanged.
- WAIT_RD: `m_req`=0.
  - On `m_rvalid`: route `m_rdata` combinationally to the owner's `*_rdata` and pulse its `*_rvalid`; the other port's rvalid stays 0. Next state: IDLE.
- `m_rvalid` in IDLE or ISSUE is ignored and is not forwarded.
- Fetch accesses drive `m_we`=0 and `m_be`=all ones.
- No grant is issued outside IDLE. A requester may drop `*_req` before its grant with no effect.
- Reset values:
  - state IDLE; all `*_gnt`, `*_rvalid`, `m_req` = 0.
  - `m_we`=0, `m_be`=0, `m_addr`=0, `m_wdata`=0, owner=i, starvation counter=0.
  - `*_rdata` = 0 whenever the matching rvalid is 0.
- Reset asserted mid-transaction: return to IDLE on that edge and drop the in-flight response. The memory is reset by the same `rst_n`.

## Timing
- Grant at cycle T (IDLE). `m_req` is high from T+1.
- Read accepted at T+1 with memory latency k≥1: `*_rvalid` at T+1+k, next grant possible at T+2+k. With k=1 the minimum is 3 cycles per read.
- Store accepted at T+1: `d_rvalid` at T+1, next grant possible at T+2.
- Grants, rvalid and rdata routing are combinational from state and inputs. All `m_*` outputs are registered.

## Configuration
- `FLINTRV_ARB_STARVE_EN` defined:
  - A 4-bit counter increments on each d grant made while `i_req`=1.
  - It clears on any i grant, and on any grant made while `i_req`=0.
  - When the counter equals `STARVE_MAX` and `i_req`=1, the next grant goes to i regardless of `d_req`.
- Undefined: strict d-over-i priority. The counter is not built, and fetch can starve indefinitely.

## Test plan
- Reset with `i_req`=`d_req`=1 held, `rst_n`=0 for 2 cycles -> no gnt and `m_req`=0 during reset; first `d_gnt` one cycle after release.
- Fetch `i_addr`=0x100, memory k=1 returning 0x00000013 -> `i_gnt` at T, `m_addr`=0x100 and `m_req` at T+1, `i_rvalid` with `i_rdata`=0x00000013 at T+2, `d_rvalid` stays 0.
- Store `d_addr`=0x2004, `d_be`=4'b0011, `d_wdata`=0xDEADBEEF, `m_ready` low for 3 cycles -> `m_*` fields held stable for 4 cycles, `d_rvalid`=1 with `d_rdata`=0 in the acceptance cycle.
- Simultaneous `i_req` and `d_req`, `d_req` held continuously, `STARVE_MAX`=4:
  - with macro -> 4 d grants, then 1 i grant, repeating.
  - without macro -> no `i_gnt` over 50 grants.
- Spurious `m_rvalid` while in IDLE and ISSUE -> no `i_rvalid`/`d_rvalid` pulse; a later correct return is delivered once.
- `rst_n` pulsed low while in WAIT_RD -> IDLE next cycle; the response arriving after reset is not forwarded; the next request completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response bundle shared by the flintRV fetch and load/store requesters,
// mem_arbiter and the unified memory port. "master" is the arbiter side.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic                d_req;
  logic                d_we;
  logic [DATA_W/8-1:0] d_be;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic                d_gnt;
  logic                d_rvalid;
  logic [DATA_W-1:0]   d_rdata;

  logic                m_req;
  logic                m_we;
  logic [DATA_W/8-1:0] m_be;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic                m_ready;
  logic                m_rvalid;
  logic [DATA_W-1:0]   m_rdata;

  modport master (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_be, m_addr, m_wdata,
    input  m_ready, m_rvalid, m_rdata
  );

  modport slave (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_be, m_addr, m_wdata,
    output m_ready, m_rvalid, m_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for flintRV: data over fetch, one transaction in flight.
// Define FLINTRV_ARB_STARVE_EN to build the fetch starvation guard.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.master bus
);
  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_e;

  state_e              state_q, state_d;
  logic                owner_d_q, owner_d_d;  // 1: load/store owns the transaction
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [BE_W-1:0]     m_be_q, m_be_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;

  logic              grant_i, grant_d, force_i;
  logic              i_rvalid, d_rvalid;
  logic [DATA_W-1:0] i_rdata, d_rdata;

`ifdef FLINTRV_ARB_STARVE_EN
  logic [3:0] starve_q, starve_d;

  assign force_i = (starve_q == 4'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (grant_i || (grant_d && !bus.i_req)) begin
      starve_d = '0;
    end else if (grant_d) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  logic unused_starve_max;

  assign force_i           = 1'b0;
  assign unused_starve_max = ^(4'(STARVE_MAX));
`endif

  // Grants and responses are suppressed while reset is held so nothing leaks out of the reset cycle.
  always_comb begin
    state_d   = state_q;
    owner_d_d = owner_d_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (rst_n) begin
          grant_i = bus.i_req && (!bus.d_req || force_i);
          grant_d = bus.d_req && !grant_i;
        end
        if (grant_d) begin
          owner_d_d = 1'b1;
          m_req_d   = 1'b1;
          m_we_d    = bus.d_we;
          m_be_d    = bus.d_be;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
          state_d   = ISSUE;
        end else if (grant_i) begin
          owner_d_d = 1'b0;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_be_d    = '1;
          m_addr_d  = bus.i_addr;
          m_wdata_d = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.m_ready) begin
          m_req_d = 1'b0;
          if (m_we_q) begin
            d_rvalid = rst_n;
            state_d  = IDLE;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (bus.m_rvalid && rst_n) begin
          if (owner_d_q) begin
            d_rvalid = 1'b1;
            d_rdata  = bus.m_rdata;
          end else begin
            i_rvalid = 1'b1;
            i_rdata  = bus.m_rdata;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_d_q <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_d_q <= owner_d_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign bus.i_gnt    = grant_i;
  assign bus.d_gnt    = grant_d;
  assign bus.i_rvalid = i_rvalid;
  assign bus.i_rdata  = i_rdata;
  assign bus.d_rvalid = d_rvalid;
  assign bus.d_rdata  = d_rdata;
  assign bus.m_req    = m_req_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_be     = m_be_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference (priority rule, starvation rule, byte-lane memory).
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BE_W       = DATA_W / 8;
  localparam int unsigned STARVE_MAX = 4;
`ifdef FLINTRV_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  typedef struct {
    bit                is_d;
    bit                we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_ready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF; bus.d_addr = 32'h8; bus.d_wdata = 32'h1234_5678;
    for (int c = 0; c < 2; c++) begin
      tick(); settle();
      checks++;
      if ({bus.i_gnt, bus.d_gnt, bus.m_req} !== 3'b000) begin
        errors++; $display("FAIL reset_quiet: got gnt_i/gnt_d/m_req=%b want 000", {bus.i_gnt, bus.d_gnt, bus.m_req});
      end
    end
    checks++;
    if ({bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata} !== '0) begin
      errors++; $display("FAIL reset_fields: got we=%b be=%h addr=%h wdata=%h want all 0", bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata);
    end
    tick(); rst_n = 1'b1; settle();
    checks++;
    if ({bus.i_gnt, bus.d_gnt} !== 2'b01) begin
      errors++; $display("FAIL reset_first_dgnt: got i/d gnt=%b want 01", {bus.i_gnt, bus.d_gnt});
    end
    tick(); bus.i_req = 1'b0; bus.d_req = 1'b0; bus.m_ready = 1'b1; settle();
    checks++;
    if ({bus.d_rvalid, bus.d_rdata, bus.m_addr, bus.m_wdata} !== {1'b1, 32'h0, 32'h8, 32'h1234_5678}) begin
      errors++; $display("FAIL reset_store_done: got rvalid=%b rdata=%h addr=%h wdata=%h want 1/0/8/12345678",
                         bus.d_rvalid, bus.d_rdata, bus.m_addr, bus.m_wdata);
    end
    tick(); bus.m_ready = 1'b0; settle();
    checks++;
    if (bus.m_req !== 1'b0) begin
      errors++; $display("FAIL reset_store_idle: got m_req=%b want 0", bus.m_req);
    end
  endtask

  task automatic test_fetch();
    tick(); bus.i_req = 1'b1; bus.i_addr = 32'h100; settle();
    checks++;
    if ({bus.i_gnt, bus.d_gnt, bus.m_req} !== 3'b100) begin
      errors++; $display("FAIL fetch_gnt: got i_gnt/d_gnt/m_req=%b want 100", {bus.i_gnt, bus.d_gnt, bus.m_req});
    end
    tick(); bus.i_req = 1'b0; bus.m_ready = 1'b1; settle();
    checks++;
    if ({bus.m_req, bus.m_we, bus.m_be, bus.m_addr, bus.i_rvalid} !== {1'b1, 1'b0, 4'hF, 32'h100, 1'b0}) begin
      errors++; $display("FAIL fetch_issue: got req=%b we=%b be=%h addr=%h rv=%b want 1/0/f/100/0",
                         bus.m_req, bus.m_we, bus.m_be, bus.m_addr, bus.i_rvalid);
    end
    tick(); bus.m_ready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h0000_0013; settle();
    checks++;
    if ({bus.i_rvalid, bus.i_rdata, bus.d_rvalid} !== {1'b1, 32'h13, 1'b0}) begin
      errors++; $display("FAIL fetch_data: got i_rvalid=%b i_rdata=%h d_rvalid=%b want 1/00000013/0",
                         bus.i_rvalid, bus.i_rdata, bus.d_rvalid);
    end
    tick(); bus.m_rvalid = 1'b0; settle();
    checks++;
    if ({bus.i_rvalid, bus.m_req} !== 2'b00) begin
      errors++; $display("FAIL fetch_after: got i_rvalid/m_req=%b want 00", {bus.i_rvalid, bus.m_req});
    end
  endtask

  task automatic test_store();
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011; bus.d_addr = 32'h2004; bus.d_wdata = 32'hDEAD_BEEF;
    settle();
    checks++;
    if ({bus.i_gnt, bus.d_gnt} !== 2'b01) begin
      errors++; $display("FAIL store_gnt: got i/d gnt=%b want 01", {bus.i_gnt, bus.d_gnt});
    end
    for (int c = 0; c < 4; c++) begin
      tick(); bus.d_req = 1'b0; bus.d_wdata = 32'h0; bus.m_ready = (c == 3); settle();
      checks++;
      if ({bus.m_req, bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hDEAD_BEEF}) begin
        errors++; $display("FAIL store_hold%0d: got req=%b we=%b be=%b addr=%h wdata=%h want 1/1/0011/2004/deadbeef",
                           c, bus.m_req, bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata);
      end
      checks++;
      if ({bus.d_rvalid, bus.d_rdata} !== {(c == 3), 32'h0}) begin
        errors++; $display("FAIL store_rvalid%0d: got rvalid=%b rdata=%h want %b/0", c, bus.d_rvalid, bus.d_rdata, (c == 3));
      end
    end
    tick(); bus.m_ready = 1'b0; settle();
    checks++;
    if ({bus.m_req, bus.d_rvalid} !== 2'b00) begin
      errors++; $display("FAIL store_after: got m_req/d_rvalid=%b want 00", {bus.m_req, bus.d_rvalid});
    end
  endtask

  // Both requesters held; memory always ready with 1-cycle read latency.
  task automatic test_starvation();
    int  g = 0;
    bit  exp_i;
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'h200;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF; bus.d_addr = 32'h400; bus.d_wdata = 32'h55;
    bus.m_ready = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h13;
    for (int cyc = 0; cyc < 400 && g < 50; cyc++) begin
      settle();
      if (bus.i_gnt === 1'b1 || bus.d_gnt === 1'b1) begin
        exp_i = STARVE_EN && (g % 5 == 4);
        checks++;
        if ({bus.i_gnt, bus.d_gnt} !== {exp_i, !exp_i}) begin
          errors++; $display("FAIL starve_grant%0d: got i/d gnt=%b want %b", g, {bus.i_gnt, bus.d_gnt}, {exp_i, !exp_i});
        end
        g++;
      end
      tick();
    end
    checks++;
    if (g != 50) begin
      errors++; $display("FAIL starve_budget: got %0d grants want 50", g);
    end
    idle_inputs();
    do_reset();
  endtask

  task automatic test_spurious();
    int deliveries = 0;
    tick(); bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h300;
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'hBAD0_0001; settle();
    checks++;
    if ({bus.d_gnt, bus.i_rvalid, bus.d_rvalid} !== 3'b100) begin
      errors++; $display("FAIL spur_idle: got gnt/i_rv/d_rv=%b want 100", {bus.d_gnt, bus.i_rvalid, bus.d_rvalid});
    end
    for (int c = 0; c < 5; c++) begin
      tick(); bus.d_req = 1'b0;
      bus.m_ready  = (c == 1);
      bus.m_rvalid = (c != 2);
      bus.m_rdata  = (c == 3) ? 32'hCAFE_F00D : 32'hBAD0_0002;
      settle();
      if (bus.d_rvalid === 1'b1) deliveries++;
      checks++;
      if ({bus.i_rvalid, bus.d_rvalid, bus.d_rdata} !== {1'b0, (c == 3), ((c == 3) ? 32'hCAFE_F00D : 32'h0)}) begin
        errors++; $display("FAIL spur_slot%0d: got i_rv=%b d_rv=%b d_rdata=%h want 0/%b/%h", c, bus.i_rvalid, bus.d_rvalid,
                           bus.d_rdata, (c == 3), ((c == 3) ? 32'hCAFE_F00D : 32'h0));
      end
    end
    checks++;
    if (deliveries != 1) begin
      errors++; $display("FAIL spur_once: got %0d deliveries want 1", deliveries);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    tick(); bus.i_req = 1'b1; bus.i_addr = 32'h180; settle();
    checks++;
    if (bus.i_gnt !== 1'b1) begin
      errors++; $display("FAIL rmid_gnt: got i_gnt=%b want 1", bus.i_gnt);
    end
    tick(); bus.i_req = 1'b0; bus.m_ready = 1'b1;
    tick(); bus.m_ready = 1'b0; rst_n = 1'b0; settle();
    checks++;
    if ({bus.i_rvalid, bus.m_req} !== 2'b00) begin
      errors++; $display("FAIL rmid_wait: got i_rvalid/m_req=%b want 00", {bus.i_rvalid, bus.m_req});
    end
    tick(); rst_n = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h5555_5555;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h1C0; settle();
    checks++;
    if ({bus.i_rvalid, bus.d_rvalid, bus.d_gnt, bus.m_req} !== 4'b0010) begin
      errors++; $display("FAIL rmid_dropped: got i_rv/d_rv/d_gnt/m_req=%b want 0010",
                         {bus.i_rvalid, bus.d_rvalid, bus.d_gnt, bus.m_req});
    end
    tick(); bus.d_req = 1'b0; bus.m_rvalid = 1'b0; bus.m_ready = 1'b1; settle();
    checks++;
    if ({bus.m_req, bus.m_we, bus.m_addr} !== {1'b1, 1'b0, 32'h1C0}) begin
      errors++; $display("FAIL rmid_next_issue: got req=%b we=%b addr=%h want 1/0/1c0", bus.m_req, bus.m_we, bus.m_addr);
    end
    tick(); bus.m_ready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h77; settle();
    checks++;
    if ({bus.d_rvalid, bus.d_rdata, bus.i_rvalid} !== {1'b1, 32'h77, 1'b0}) begin
      errors++; $display("FAIL rmid_next_data: got d_rv=%b d_rdata=%h i_rv=%b want 1/77/0", bus.d_rvalid, bus.d_rdata, bus.i_rvalid);
    end
    idle_inputs();
  endtask

  // Randomized traffic: phase 0 = no transaction, 1 = waiting for acceptance, 2 = waiting for read data.
  task automatic test_random();
    logic [DATA_W-1:0] ref_mem [16];
    logic [DATA_W-1:0] dev_mem [16];
    txn_t              cur;
    int                phase = 0;
    int                cd = 0;
    int                ref_cnt = 0;
    bit                i_took = 0, d_took = 0, exp_gnt, exp_i;
    logic [DATA_W-1:0] rd_data = '0;
    int                idx;

    for (int k = 0; k < 16; k++) begin
      ref_mem[k] = $urandom;
      dev_mem[k] = ref_mem[k];
    end
    cur = '{default: '0};
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (i_took) bus.i_req = 1'b0;
      if (d_took) bus.d_req = 1'b0;
      if (!bus.i_req && $urandom_range(2) == 0) begin
        bus.i_req = 1'b1; bus.i_addr = ADDR_W'($urandom_range(15) << 2);
      end else if (bus.i_req && $urandom_range(15) == 0) begin
        bus.i_req = 1'b0;
      end
      if (!bus.d_req && $urandom_range(2) == 0) begin
        bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(1)); bus.d_be = BE_W'($urandom);
        bus.d_addr = ADDR_W'($urandom_range(15) << 2); bus.d_wdata = $urandom;
      end else if (bus.d_req && $urandom_range(15) == 0) begin
        bus.d_req = 1'b0;
      end
      bus.m_ready  = 1'($urandom_range(1));
      bus.m_rdata  = $urandom;
      bus.m_rvalid = 1'b0;
      if (phase == 2) begin
        cd--;
        if (cd == 0) begin bus.m_rvalid = 1'b1; bus.m_rdata = rd_data; end
      end else if ($urandom_range(3) == 0) begin
        bus.m_rvalid = 1'b1;
      end
      settle();
      i_took = 0; d_took = 0;

      if (phase == 2 && bus.m_rvalid) begin
        checks++;
        if ({bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata} !==
            {!cur.is_d, cur.is_d, (cur.is_d ? 32'h0 : cur.rdata), (cur.is_d ? cur.rdata : 32'h0)}) begin
          errors++; $display("FAIL rand_read_cyc%0d: got i_rv=%b d_rv=%b i_rd=%h d_rd=%h want owner_d=%b data=%h",
                             cyc, bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata, cur.is_d, cur.rdata);
        end
        phase = 0;
      end else if (phase == 1) begin
        checks++;
        if ({bus.m_req, bus.m_we, bus.m_be, bus.m_addr} !== {1'b1, cur.we, cur.be, cur.addr} ||
            (cur.we && bus.m_wdata !== cur.wdata)) begin
          errors++; $display("FAIL rand_issue_cyc%0d: got req=%b we=%b be=%h addr=%h wdata=%h want 1/%b/%h/%h/%h",
                             cyc, bus.m_req, bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata, cur.we, cur.be, cur.addr, cur.wdata);
        end
        checks++;
        if ({bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata} !== {1'b0, (bus.m_ready && cur.we), 64'h0}) begin
          errors++; $display("FAIL rand_issue_rv_cyc%0d: got i_rv=%b d_rv=%b d_rd=%h want d_rv=%b rdata 0",
                             cyc, bus.i_rvalid, bus.d_rvalid, bus.d_rdata, (bus.m_ready && cur.we));
        end
        if (bus.m_ready) begin
          idx = int'(bus.m_addr[5:2]);
          if (cur.we) begin
            for (int b = 0; b < int'(BE_W); b++)
              if (bus.m_be[b]) dev_mem[idx][8*b +: 8] = bus.m_wdata[8*b +: 8];
            phase = 0;
          end else begin
            rd_data = dev_mem[idx];
            cd      = $urandom_range(1, 3);
            phase   = 2;
          end
        end
      end else begin
        checks++;
        if ({bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata} !== '0) begin
          errors++; $display("FAIL rand_quiet_cyc%0d: got i_rv=%b d_rv=%b i_rd=%h d_rd=%h want all 0",
                             cyc, bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata);
        end
        exp_gnt = (phase == 0) && (bus.i_req || bus.d_req);
        exp_i   = bus.i_req && (!bus.d_req || (STARVE_EN && ref_cnt == int'(STARVE_MAX)));
        checks++;
        if ({bus.i_gnt, bus.d_gnt, bus.m_req} !== {exp_gnt && exp_i, exp_gnt && !exp_i, (phase == 1)}) begin
          errors++; $display("FAIL rand_grant_cyc%0d: got i/d gnt,m_req=%b want %b", cyc, {bus.i_gnt, bus.d_gnt, bus.m_req},
                             {exp_gnt && exp_i, exp_gnt && !exp_i, (phase == 1)});
        end
        if (exp_gnt) begin
          if (exp_i) begin
            cur = '{is_d: 1'b0, we: 1'b0, be: '1, addr: bus.i_addr, wdata: '0, rdata: ref_mem[bus.i_addr[5:2]]};
            i_took = 1;
          end else begin
            cur = '{is_d: 1'b1, we: bus.d_we, be: bus.d_be, addr: bus.d_addr, wdata: bus.d_wdata, rdata: '0};
            if (!bus.d_we) cur.rdata = ref_mem[bus.d_addr[5:2]];
            else
              for (int b = 0; b < int'(BE_W); b++)
                if (bus.d_be[b]) ref_mem[bus.d_addr[5:2]][8*b +: 8] = bus.d_wdata[8*b +: 8];
            d_took = 1;
          end
          ref_cnt = (exp_i || !bus.i_req) ? 0 : ref_cnt + 1;
          phase   = 1;
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_starvation();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
